// File: rtl/inference_scheduler.sv
// Shares one neural-network accelerator between NUM_REQ requesters: round-robin grant,
// start/watchdog the accelerator, sequential argmax of its outputs, respond, then reset it.
module inference_scheduler #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned NUM_OUT        = 10,
    parameter int unsigned ACT_W          = 15,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               busy,
    output logic                               accel_start,
    output logic                               accel_rst,
    input  logic                               accel_done,
    input  logic [NUM_OUT-1:0][ACT_W-1:0]      act_in,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]         resp_id,
    output logic [$clog2(NUM_OUT)-1:0]         resp_class,
    output logic signed [ACT_W-1:0]            resp_score,
    output logic                               resp_err,
    output logic                               timeout_err
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CLS_W = $clog2(NUM_OUT);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        RUN     = 3'd2,
        ARGMAX  = 3'd3,
        RESP    = 3'd4,
        RECOVER = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ID_W-1:0]         rr_ptr;
    logic [WD_W-1:0]         watchdog;
    logic [CLS_W-1:0]        idx;
    logic                    gnt_found;
    logic [ID_W-1:0]         gnt_idx;
    logic [ID_W-1:0]         cand;
    logic signed [ACT_W-1:0] cur_act;
    logic                    take_new;
    logic                    wd_expired;
    logic                    idx_last;

    // Round-robin search: first valid requester after the last one served.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign cur_act    = act_in[idx];
    assign take_new   = (idx == '0) || (cur_act > resp_score);
    assign wd_expired = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign idx_last   = (idx == CLS_W'(NUM_OUT - 1));
    assign resp_id    = grant_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_found) state_next = START;
            START:   state_next = RUN;
            RUN: begin
                // done takes precedence over a coincident watchdog expiry
                if (accel_done)      state_next = ARGMAX;
                else if (wd_expired) state_next = RESP;
            end
            ARGMAX:  if (idx_last) state_next = RESP;
            RESP:    if (resp_ready) state_next = RECOVER;
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        busy        = (state != IDLE);
        accel_start = (state == START);
        accel_rst   = (state == RECOVER);
        resp_valid  = (state == RESP);
        timeout_err = (state == RUN) && !accel_done && wd_expired;
        if ((state == IDLE) && gnt_found && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Job datapath: grant capture, watchdog, argmax scan and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= ID_W'(NUM_REQ - 1);
            grant_id   <= '0;
            watchdog   <= '0;
            idx        <= '0;
            resp_class <= '0;
            resp_score <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        grant_id   <= gnt_idx;
                        resp_err   <= 1'b0;
                        resp_class <= '0;
                        resp_score <= '0;
                    end
                end
                START: begin
                    watchdog <= '0;
                    idx      <= '0;
                end
                RUN: begin
                    if (accel_done) begin
                        idx <= '0;
                    end else if (wd_expired) begin
                        resp_err   <= 1'b1;
                        resp_class <= '0;
                        resp_score <= '0;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                ARGMAX: begin
                    if (take_new) begin
                        resp_class <= idx;
                        resp_score <= cur_act;
                    end
                    if (!idx_last) begin
                        idx <= idx + CLS_W'(1);
                    end
                end
                RECOVER: rr_ptr <= grant_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inference_scheduler.sv
// Directed bench for inference_scheduler: table of argmax jobs plus hand-written sequences
// for arbitration, response back-pressure, watchdog timeout and mid-job reset.
module tb_inference_scheduler;

    typedef logic [9:0][14:0] act_t;

    typedef struct packed {
        logic [1:0] valid;
        act_t       act;
        int         exp_id;
        int         exp_cls;
        int         exp_score;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [0:0] grant_id;
    logic       busy, accel_start, accel_rst, accel_done;
    act_t       acts = '0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [0:0] resp_id;
    logic [3:0] resp_class;
    logic signed [14:0] resp_score;
    logic       resp_err, timeout_err;

    logic [1:0] req_valid2 = '0;
    logic [1:0] req_ready2;
    logic [0:0] grant_id2, resp_id2;
    logic       busy2, accel_start2, accel_rst2, resp_valid2, resp_err2, timeout_err2;
    logic       resp_ready2 = 1'b0;
    logic       accel_done2 = 1'b0;
    act_t       acts2 = '0;
    logic [3:0] resp_class2;
    logic signed [14:0] resp_score2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_start = 0;
    int done_delay = 5;
    int mcnt = 0;
    logic mrun = 1'b0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    inference_scheduler #(.NUM_REQ(2), .NUM_OUT(10), .ACT_W(15), .TIMEOUT_CYCLES(512)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .grant_id(grant_id), .busy(busy), .accel_start(accel_start), .accel_rst(accel_rst),
        .accel_done(accel_done), .act_in(acts), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_class(resp_class), .resp_score(resp_score),
        .resp_err(resp_err), .timeout_err(timeout_err)
    );

    inference_scheduler #(.NUM_REQ(2), .NUM_OUT(10), .ACT_W(15), .TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .grant_id(grant_id2), .busy(busy2), .accel_start(accel_start2), .accel_rst(accel_rst2),
        .accel_done(accel_done2), .act_in(acts2), .resp_valid(resp_valid2), .resp_ready(resp_ready2),
        .resp_id(resp_id2), .resp_class(resp_class2), .resp_score(resp_score2),
        .resp_err(resp_err2), .timeout_err(timeout_err2)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (accel_start) n_start <= n_start + 1;

    // Accelerator model: done rises done_delay cycles after the start pulse, held until accel_rst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            accel_done <= 1'b0; mrun <= 1'b0; mcnt <= 0;
        end else if (accel_rst) begin
            accel_done <= 1'b0; mrun <= 1'b0; mcnt <= 0;
        end else if (accel_start) begin
            mrun <= 1'b1; mcnt <= 1;
        end else if (mrun && !accel_done) begin
            if (mcnt == done_delay - 1) accel_done <= 1'b1;
            mcnt <= mcnt + 1;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic act_t fill(input int base);
        act_t r;
        for (int i = 0; i < 10; i++) r[i] = 15'(base);
        return r;
    endfunction

    // One full job on the main DUT; called at a negedge, returns at the negedge after RECOVER.
    task automatic do_job(input logic [1:0] valid, input int exp_id, input int exp_cls,
                          input int exp_score, input int exp_lat, input bit keep, input string tag);
        int t0;
        bit got;
        req_valid = valid;
        got = 1'b0;
        for (int w = 0; w < 20; w++) begin
            #1;
            if (req_ready != 2'b00) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk({tag, "_req_ready"}, int'(req_ready), 1 << exp_id);
        if (!got) return;
        t0 = cyc;
        @(negedge clk);
        if (!keep) req_valid = '0;
        chk({tag, "_start"}, int'(accel_start), 1);
        chk({tag, "_grant_id"}, int'(grant_id), exp_id);
        @(negedge clk);
        chk({tag, "_start_pulse"}, int'(accel_start), 0);
        got = 1'b0;
        for (int w = 0; w < 1000; w++) begin
            if (resp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk({tag, "_resp_seen"}, int'(got), 1);
        if (exp_lat > 0) chk({tag, "_latency"}, cyc - t0, exp_lat);
        chk({tag, "_resp_id"}, int'(resp_id), exp_id);
        chk({tag, "_resp_class"}, int'(resp_class), exp_cls);
        chk({tag, "_resp_score"}, int'(resp_score), exp_score);
        chk({tag, "_resp_err"}, int'(resp_err), 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_accel_rst"}, int'(accel_rst), 1);
        chk({tag, "_resp_drop"}, int'(resp_valid), 0);
        @(negedge clk);
        chk({tag, "_accel_rst_pulse"}, int'(accel_rst), 0);
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int t0;
        int s0;
        bit got;

        vecs[0].valid = 2'b10; vecs[0].act = fill(7);
        vecs[0].act[2] = 15'(120); vecs[0].act[5] = 15'(120); vecs[0].act[9] = 15'(119);
        vecs[0].exp_id = 1; vecs[0].exp_cls = 2; vecs[0].exp_score = 120;
        vecs[1].valid = 2'b01; vecs[1].act = fill(-100);
        vecs[1].act[9] = 15'(-3); vecs[1].act[0] = 15'(-4);
        vecs[1].exp_id = 0; vecs[1].exp_cls = 9; vecs[1].exp_score = -3;
        vecs[2].valid = 2'b10; vecs[2].act = fill(0);
        vecs[2].exp_id = 1; vecs[2].exp_cls = 0; vecs[2].exp_score = 0;
        vecs[3].valid = 2'b01; vecs[3].act = fill(-2);
        vecs[3].act[0] = 15'(16383); vecs[3].act[1] = 15'(16383);
        vecs[3].exp_id = 0; vecs[3].exp_cls = 0; vecs[3].exp_score = 16383;
        vecs[4].valid = 2'b10; vecs[4].act = fill(-16384); vecs[4].act[4] = 15'(-16383);
        vecs[4].exp_id = 1; vecs[4].exp_cls = 4; vecs[4].exp_score = -16383;
        vecs[5].valid = 2'b01; vecs[5].act = fill(50);
        vecs[5].act[3] = 15'(-1); vecs[5].act[6] = 15'(100);
        vecs[5].exp_id = 0; vecs[5].exp_cls = 6; vecs[5].exp_score = 100;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", int'({req_ready, grant_id, busy, accel_start, accel_rst, resp_valid,
                                 resp_id, resp_class, resp_err, timeout_err}), 0);
        chk("rst_score", int'(resp_score), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_no_ready", int'(req_ready), 0);

        // single job, done 386 cycles after start, argmax at index 7
        done_delay = 386;
        acts = fill(10);
        acts[7] = 15'(300); acts[3] = 15'(299); acts[8] = 15'(-500);
        do_job(2'b01, 0, 7, 300, 398, 1'b0, "job1");

        // argmax table
        done_delay = 5;
        for (int i = 0; i < 6; i++) begin
            acts = vecs[i].act;
            do_job(vecs[i].valid, vecs[i].exp_id, vecs[i].exp_cls, vecs[i].exp_score, 17,
                   1'b0, $sformatf("vec%0d", i));
        end

        // both requesters continuously valid: grants alternate
        acts = vecs[5].act;
        s0 = n_start;
        do_job(2'b11, 1, 6, 100, 17, 1'b1, "rr0");
        do_job(2'b11, 0, 6, 100, 17, 1'b1, "rr1");
        do_job(2'b11, 1, 6, 100, 17, 1'b1, "rr2");
        do_job(2'b11, 0, 6, 100, 17, 1'b0, "rr3");
        chk("rr_start_count", n_start - s0, 4);

        // response back-pressure with a competing request
        acts = vecs[1].act;
        req_valid = 2'b01;
        got = 1'b0;
        for (int w = 0; w < 20; w++) begin
            #1;
            if (req_ready != 2'b00) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("bp_req_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b10;
        got = 1'b0;
        for (int w = 0; w < 100; w++) begin
            if (resp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("bp_resp_seen", int'(got), 1);
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(resp_valid), 1);
            chk("bp_hold_class", int'(resp_class), 9);
            chk("bp_hold_score", int'(resp_score), -3);
            chk("bp_no_accept", int'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_accel_rst", int'(accel_rst), 1);
        chk("bp_recover_no_accept", int'(req_ready), 0);
        @(negedge clk);
        do_job(2'b10, 1, 9, -3, 17, 1'b0, "bp_next");
        do_job(2'b01, 0, 9, -3, 17, 1'b0, "pre_rst");

        // asynchronous reset in the middle of RUN
        done_delay = 386;
        req_valid = 2'b10;
        got = 1'b0;
        for (int w = 0; w < 20; w++) begin
            #1;
            if (req_ready != 2'b00) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("mr_req_ready", int'(req_ready), 2);
        @(negedge clk);
        req_valid = '0;
        repeat (20) @(negedge clk);
        chk("mr_in_run", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("mr_outputs", int'({req_ready, grant_id, busy, accel_start, accel_rst, resp_valid,
                                resp_id, resp_class, resp_err, timeout_err}), 0);
        chk("mr_score", int'(resp_score), 0);
        @(negedge clk);
        @(negedge clk);
        chk("mr_no_resp", int'(resp_valid), 0);
        rst = 1'b0;
        done_delay = 5;
        acts = vecs[3].act;
        do_job(2'b11, 0, 0, 16383, 17, 1'b0, "post_rst");

        // watchdog timeout on the short-timeout instance
        req_valid2 = 2'b01;
        got = 1'b0;
        for (int w = 0; w < 20; w++) begin
            #1;
            if (req_ready2 != 2'b00) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("to_req_ready", int'(req_ready2), 1);
        t0 = cyc;
        @(negedge clk);
        req_valid2 = '0;
        chk("to_start", int'(accel_start2), 1);
        repeat (15) @(negedge clk);
        chk("to_not_yet", int'(timeout_err2), 0);
        chk("to_still_run", int'(resp_valid2), 0);
        @(negedge clk);
        chk("to_pulse_cycle", cyc - (t0 + 1), 16);
        chk("to_pulse", int'(timeout_err2), 1);
        @(negedge clk);
        chk("to_pulse_end", int'(timeout_err2), 0);
        chk("to_resp_valid", int'(resp_valid2), 1);
        chk("to_resp_err", int'(resp_err2), 1);
        chk("to_resp_class", int'(resp_class2), 0);
        chk("to_resp_score", int'(resp_score2), 0);
        resp_ready2 = 1'b1;
        @(negedge clk);
        resp_ready2 = 1'b0;
        chk("to_accel_rst", int'(accel_rst2), 1);
        @(negedge clk);
        chk("to_idle", int'(busy2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected to finish", cyc);
        $fatal(1, "bench time limit expired");
    end

endmodule
